// File: rtl/uart_tx_arbiter_if.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester handshake and the uart_tx hand-off signals that the
//   arbiter sits between.
//
//   Signals
//     req_valid [NREQ-1:0]   requester i offers a byte
//     req_data  [8*NREQ-1:0] flattened request bytes, byte i at [8i+7:8i]
//     req_last  [NREQ-1:0]   last byte of a locked burst (UART_ARB_LOCK_EN only)
//     req_ready [NREQ-1:0]   one-cycle capture pulse back to requester i
//     tx_ready               uart_tx idle
//     tx_accept              uart_tx latched tx_byte this cycle
//     tx_start               start request to uart_tx
//     tx_byte   [7:0]        byte presented to uart_tx
//
//   Modports
//     slave  : arbiter view (serves requesters, drives uart_tx)
//     master : environment view (requesters plus uart_tx)
//
//   Optional feature macro: UART_ARB_LOCK_EN adds req_last.
// ----------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]   req_last;
`endif
  logic              tx_ready;
  logic              tx_accept;
  logic              tx_start;
  logic [7:0]        tx_byte;

`ifdef UART_ARB_LOCK_EN
  modport slave (
    input  req_valid, req_data, req_last, tx_ready, tx_accept,
    output req_ready, tx_start, tx_byte
  );
  modport master (
    output req_valid, req_data, req_last, tx_ready, tx_accept,
    input  req_ready, tx_start, tx_byte
  );
`else
  modport slave (
    input  req_valid, req_data, tx_ready, tx_accept,
    output req_ready, tx_start, tx_byte
  );
  modport master (
    output req_valid, req_data, tx_ready, tx_accept,
    input  req_ready, tx_start, tx_byte
  );
`endif
endinterface

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx transmitter between NREQ byte producers with
//   round-robin arbitration, one byte per grant. A granted byte is captured
//   and acknowledged immediately (req_ready pulse), then offered to uart_tx
//   via tx_start/tx_byte until tx_accept. A one-cycle GAP follows every
//   accept so uart_tx can drop tx_ready before the next arbitration.
//
//   Parameters
//     NREQ        number of requesters (2..8)
//     ACC_TIMEOUT cycles allowed in ISSUE before the hand-off is aborted
//
//   Ports
//     clk          system clock, rising edge
//     rstn         synchronous active-low reset
//     bus          uart_tx_arbiter_if.slave (requesters + uart_tx hand-off)
//     grant_id     index of the last/current granted requester
//     busy         high whenever the FSM is not IDLE
//     timeout_err  one-cycle pulse when a hand-off times out
//
//   Optional feature macro: UART_ARB_LOCK_EN. When defined, a byte captured
//   with req_last=0 locks arbitration to that requester until a byte with
//   req_last=1 is captured. The lock survives timeout aborts.
// ----------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NREQ        = 4,
  parameter int ACC_TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rstn,
  uart_tx_arbiter_if.slave        bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(ACC_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [IW-1:0]     ptr_r;
  logic [CW-1:0]     cnt_r;
  logic              tx_start_r;
  logic [7:0]        tx_byte_r;
  logic [NREQ-1:0]   req_ready_r;
  logic [IW-1:0]     grant_id_r;
  logic              busy_r;
  logic              timeout_err_r;

  logic [NREQ-1:0]   cand_s;
  logic              pick_found_s;
  logic [IW-1:0]     pick_idx_s;
  logic              grant_s;
  logic              abort_s;

  logic [IW-1:0]     ptr_d;
  logic [CW-1:0]     cnt_d;
  logic              tx_start_d;
  logic [7:0]        tx_byte_d;
  logic [NREQ-1:0]   req_ready_d;
  logic [IW-1:0]     grant_id_d;
  logic              busy_d;
  logic              timeout_err_d;

`ifdef UART_ARB_LOCK_EN
  logic              lock_r;
  logic              lock_d;
`endif

  // Round-robin search starting at ptr, wrapping NREQ-1 -> 0.
  // Returns {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] cand,
                                          input logic [IW-1:0]   ptr);
    logic          found;
    logic [IW-1:0] sel;
    logic [IW-1:0] pos;
    int            idx;
    found = 1'b0;
    sel   = {IW{1'b0}};
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      idx = (idx >= NREQ) ? (idx - NREQ) : idx;
      pos = idx[IW-1:0];
      if (!found && cand[pos]) begin
        found = 1'b1;
        sel   = pos;
      end else begin
        found = found;
      end
    end
    return {found, sel};
  endfunction

  // Candidate set: while locked only the locked requester may be granted.
  always_comb begin
    cand_s = bus.req_valid;
`ifdef UART_ARB_LOCK_EN
    if (lock_r) begin
      cand_s = bus.req_valid & (NREQ'(1'b1) << grant_id_r);
    end else begin
      cand_s = bus.req_valid;
    end
`endif
    {pick_found_s, pick_idx_s} = rr_pick(cand_s, ptr_r);
  end

  // Grant and abort qualifiers shared by next-state and output logic.
  always_comb begin
    grant_s = (state_r == IDLE) && bus.tx_ready && pick_found_s;
    abort_s = (state_r == ISSUE) && !bus.tx_accept && (cnt_r == CW'(ACC_TIMEOUT - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; accept wins over a coincident timeout.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.tx_accept) begin
          state_s = GAP;
        end else if (abort_s) begin
          state_s = IDLE;
        end else begin
          state_s = ISSUE;
        end
      end
      GAP:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and datapath.
  always_comb begin
    tx_start_d    = (state_s == ISSUE);
    busy_d        = (state_s != IDLE);
    timeout_err_d = abort_s;
    req_ready_d   = {NREQ{1'b0}};
    tx_byte_d     = tx_byte_r;
    grant_id_d    = grant_id_r;
    ptr_d         = ptr_r;
    cnt_d         = cnt_r;
`ifdef UART_ARB_LOCK_EN
    lock_d        = lock_r;
`endif
    if (grant_s) begin
      req_ready_d = NREQ'(1'b1) << pick_idx_s;
      tx_byte_d   = bus.req_data[{pick_idx_s, 3'b000} +: 8];
      grant_id_d  = pick_idx_s;
      ptr_d       = (pick_idx_s == IW'(NREQ - 1)) ? {IW{1'b0}} : (pick_idx_s + IW'(1));
      cnt_d       = {CW{1'b0}};
`ifdef UART_ARB_LOCK_EN
      lock_d      = ~bus.req_last[pick_idx_s];
`endif
    end else if (state_r == ISSUE) begin
      cnt_d = cnt_r + CW'(1);
    end else begin
      cnt_d = cnt_r;
    end
  end

  // Registered outputs, round-robin pointer and timeout counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_start_r    <= 1'b0;
      tx_byte_r     <= 8'h00;
      req_ready_r   <= {NREQ{1'b0}};
      grant_id_r    <= {IW{1'b0}};
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      ptr_r         <= {IW{1'b0}};
      cnt_r         <= {CW{1'b0}};
`ifdef UART_ARB_LOCK_EN
      lock_r        <= 1'b0;
`endif
    end else begin
      tx_start_r    <= tx_start_d;
      tx_byte_r     <= tx_byte_d;
      req_ready_r   <= req_ready_d;
      grant_id_r    <= grant_id_d;
      busy_r        <= busy_d;
      timeout_err_r <= timeout_err_d;
      ptr_r         <= ptr_d;
      cnt_r         <= cnt_d;
`ifdef UART_ARB_LOCK_EN
      lock_r        <= lock_d;
`endif
    end
  end

  assign bus.tx_start  = tx_start_r;
  assign bus.tx_byte   = tx_byte_r;
  assign bus.req_ready = req_ready_r;
  assign grant_id      = grant_id_r;
  assign busy          = busy_r;
  assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NREQ=4, ACC_TIMEOUT=16). The bench
//   plays both the requesters and a behavioural uart_tx. Expected bytes and
//   grant ids are queued when a request is set up and popped when the bench's
//   uart_tx accepts a byte.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_err;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_byte_q[$];
  logic [7:0] exp_gid_q[$];

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .ACC_TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    bus.req_data[8*i +: 8] = b;
  endtask

  task automatic expect_tx(input logic [7:0] b, input logic [7:0] g);
    exp_byte_q.push_back(b);
    exp_gid_q.push_back(g);
  endtask

  // Wait for a req_ready pulse, check it, apply next_valid, then check the
  // pulse has cleared and the byte is being offered to uart_tx.
  task automatic wait_grant(input string tag, input logic [3:0] mask,
                            input logic [1:0] gid, input logic [3:0] next_valid);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0000) found = 1'b1;
    end
    chk({tag, "_grant_seen"}, {31'd0, found}, 32'd1);
    if (found) begin
      chk({tag, "_req_ready"}, {28'd0, bus.req_ready}, {28'd0, mask});
      chk({tag, "_grant_id"}, {30'd0, grant_id}, {30'd0, gid});
    end
    bus.req_valid = next_valid;
    @(negedge clk);
    chk({tag, "_ready_pulse_end"}, {28'd0, bus.req_ready}, 32'd0);
    chk({tag, "_tx_start"}, {31'd0, bus.tx_start}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
  endtask

  // Behavioural uart_tx: accept after 'delay' cycles, then stay busy.
  task automatic serve_one(input string tag, input int delay, input int busy_cycles);
    logic       found;
    logic [7:0] eb;
    logic [7:0] eg;
    found = bus.tx_start;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      found = bus.tx_start;
    end
    chk({tag, "_start_seen"}, {31'd0, found}, 32'd1);
    repeat (delay) @(negedge clk);
    chk({tag, "_start_held"}, {31'd0, bus.tx_start}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'd0, exp_byte_q.size() != 0}, 32'd1);
    if (exp_byte_q.size() != 0) begin
      eb = exp_byte_q.pop_front();
      eg = exp_gid_q.pop_front();
      chk({tag, "_tx_byte"}, {24'd0, bus.tx_byte}, {24'd0, eb});
      chk({tag, "_tx_gid"}, {30'd0, grant_id}, {24'd0, eg});
    end
    bus.tx_accept = 1'b1;
    @(negedge clk);
    bus.tx_accept = 1'b0;
    bus.tx_ready  = 1'b0;
    chk({tag, "_start_drop"}, {31'd0, bus.tx_start}, 32'd0);
    chk({tag, "_gap_busy"}, {31'd0, busy}, 32'd1);
    repeat (busy_cycles) @(negedge clk);
    bus.tx_ready = 1'b1;
  endtask

  initial begin
    int hi;
    rstn          = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_data  = 32'h0000_0000;
    bus.tx_ready  = 1'b1;
    bus.tx_accept = 1'b0;
`ifdef UART_ARB_LOCK_EN
    bus.req_last  = 4'b0000;
`endif

    // 1. Reset held with all requesters valid.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    end
    chk("rst_tx_byte", {24'd0, bus.tx_byte}, 32'h00);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    bus.req_valid = 4'b0000;
    rstn = 1'b1;
    @(negedge clk);

    // 2. Single requester 2 sends 0x41.
    set_byte(2, 8'h41);
    bus.req_valid = 4'b0100;
    expect_tx(8'h41, 8'd2);
    wait_grant("single", 4'b0100, 2'd2, 4'b0000);
    serve_one("single", 2, 3);
    chk("single_idle", {31'd0, busy}, 32'd0);

    // Stray accept while idle must be ignored.
    bus.tx_accept = 1'b1;
    @(negedge clk);
    bus.tx_accept = 1'b0;
    chk("stray_accept_busy", {31'd0, busy}, 32'd0);
    chk("stray_accept_start", {31'd0, bus.tx_start}, 32'd0);

    // 3. Contention from a fresh pointer: order 0,1,2,3,0.
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) set_byte(i, 8'h30 + 8'(i));
    bus.req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      expect_tx(8'h30 + 8'(g % 4), 8'(g % 4));
      wait_grant("rr", 4'(1 << (g % 4)), 2'(g % 4), 4'b1111);
      serve_one("rr", 1, 2);
    end
    bus.req_valid = 4'b0000;

    // 4. Timeout: uart_tx never accepts.
    set_byte(1, 8'h55);
    bus.req_valid = 4'b0010;
    wait_grant("tmo", 4'b0010, 2'd1, 4'b0000);
    hi = 2;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.tx_start) hi++;
      else break;
    end
    chk("tmo_start_cycles", hi, TMO);
    chk("tmo_err_pulse", {31'd0, timeout_err}, 32'd1);
    chk("tmo_idle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("tmo_err_clear", {31'd0, timeout_err}, 32'd0);
    set_byte(0, 8'h66);
    bus.req_valid = 4'b0001;
    expect_tx(8'h66, 8'd0);
    wait_grant("post_tmo", 4'b0001, 2'd0, 4'b0000);
    serve_one("post_tmo", 1, 2);

    // 5. Reset while tx_start is high.
    set_byte(3, 8'h77);
    bus.req_valid = 4'b1000;
    wait_grant("rst_mid", 4'b1000, 2'd3, 4'b0000);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_mid_start", {31'd0, bus.tx_start}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_gid", {30'd0, grant_id}, 32'd0);
    for (int i = 0; i < 4; i++) set_byte(i, 8'h30 + 8'(i));
    bus.req_valid = 4'b1111;
    expect_tx(8'h30, 8'd0);
    wait_grant("after_rst", 4'b0001, 2'd0, 4'b0000);
    serve_one("after_rst", 1, 2);

    // 6. Requester 1 sends 0x7A then 0x7B while requester 0 waits with 0x10.
    set_byte(1, 8'h7A);
    set_byte(0, 8'h10);
    bus.req_valid = 4'b0011;
`ifdef UART_ARB_LOCK_EN
    bus.req_last = 4'b0000;
    expect_tx(8'h7A, 8'd1);
    expect_tx(8'h7B, 8'd1);
    expect_tx(8'h10, 8'd0);
    wait_grant("lock_a", 4'b0010, 2'd1, 4'b0011);
    set_byte(1, 8'h7B);
    bus.req_last = 4'b0010;
    serve_one("lock_a", 1, 2);
    wait_grant("lock_b", 4'b0010, 2'd1, 4'b0001);
    serve_one("lock_b", 1, 2);
    wait_grant("lock_c", 4'b0001, 2'd0, 4'b0000);
    serve_one("lock_c", 1, 2);
`else
    expect_tx(8'h7A, 8'd1);
    expect_tx(8'h10, 8'd0);
    expect_tx(8'h7B, 8'd1);
    wait_grant("nolock_a", 4'b0010, 2'd1, 4'b0011);
    set_byte(1, 8'h7B);
    serve_one("nolock_a", 1, 2);
    wait_grant("nolock_b", 4'b0001, 2'd0, 4'b0010);
    serve_one("nolock_b", 1, 2);
    wait_grant("nolock_c", 4'b0010, 2'd1, 4'b0000);
    serve_one("nolock_c", 1, 2);
`endif

    chk("sb_drained", exp_byte_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
